// File: rtl/jtdsp16_cache.sv
// jtdsp16_cache -- do-loop instruction cache for the DSP16 core.
//
// Sits between program ROM fetch and the instruction decoder. On a "do"
// request it captures the loop body (up to 15 words) during the first ROM
// pass. It then replays the body for the remaining iterations while the PC
// is held. A "redo" (NI=0) replays the last captured body with no ROM pass.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   cen             clock enable; state advances only when high
//   do_start        one-cen-cycle do/redo request from the decoder
//   do_data[10:0]   [10:7] NI body length (0 = redo), [6:0] K iteration count
//   fetch           decoder consumes an instruction word this cen cycle
//   rom_dout[15:0]  instruction word from program ROM
//   cache_dout      replayed word (0 when cache_sel is low)
//   cache_sel       decoder takes its instruction from cache_dout
//   pc_halt         PC must not advance
//   no_int          interrupts blocked while the loop machinery is active
//   busy            state is not IDLE
//   fault           sticky: do_start arrived while busy
module jtdsp16_cache #(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        do_start,
    input  logic [10:0] do_data,
    input  logic        fetch,
    input  logic [15:0] rom_dout,
    output logic [15:0] cache_dout,
    output logic        cache_sel,
    output logic        pc_halt,
    output logic        no_int,
    output logic        busy,
    output logic        fault
);

    localparam int DEPTH = (1 << AW) - 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] REPLAY = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] idx;
    logic [3:0]    ni_q;
    logic [6:0]    iter_left;
    logic [15:0]   mem [0:DEPTH-1];

    logic [3:0]    ni;
    logic [6:0]    k;
    logic [6:0]    k_m1;
    logic [AW-1:0] last_idx;
    logic          mem_we;
    logic [AW-1:0] mem_wa;

    assign ni       = do_data[10:7];
    assign k        = do_data[6:0];
    // K=0 on a real do still captures one ROM pass, so it behaves as K=1.
    assign k_m1     = (k == 7'd0) ? 7'd0 : k - 7'd1;
    assign last_idx = AW'(ni_q - 4'd1);

    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = idx;
        if (cen) begin
            if (state == IDLE && do_start && ni != 4'd0) begin
                // Body word 0 is on rom_dout in the same cycle as the request.
                mem_we = 1'b1;
                mem_wa = '0;
            end else if (state == LOAD && fetch) begin
                mem_we = 1'b1;
            end
        end
    end

    // NOTE: the body storage has no reset; it is only meaningful once ni_q
    // says a body was captured, and resetting it would cost a reset net per bit.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= rom_dout;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            iter_left <= 7'd0;
            ni_q      <= 4'd0;
            fault     <= 1'b0;
        end else if (cen) begin
            // Loops do not nest: a request while busy is dropped and flagged.
            if (do_start && state != IDLE) fault <= 1'b1;
            case (state)
                IDLE: begin
                    if (do_start) begin
                        if (ni != 4'd0) begin
                            ni_q      <= ni;
                            iter_left <= k_m1;
                            idx       <= AW'(1);
                            if (ni != 4'd1) begin
                                state <= LOAD;
                            end else if (k_m1 != 7'd0) begin
                                // One-word body already fully captured.
                                state <= REPLAY;
                                idx   <= '0;
                            end
                        end else if (k != 7'd0 && ni_q != 4'd0) begin
                            iter_left <= k;
                            idx       <= '0;
                            state     <= REPLAY;
                        end
                    end
                end
                LOAD: begin
                    if (fetch) begin
                        idx <= idx + AW'(1);
                        if (idx == last_idx) begin
                            if (iter_left == 7'd0) begin
                                state <= IDLE;
                            end else begin
                                state <= REPLAY;
                                idx   <= '0;
                            end
                        end
                    end
                end
                REPLAY: begin
                    if (fetch) begin
                        if (idx == last_idx) begin
                            idx       <= '0;
                            iter_left <= iter_left - 7'd1;
                            if (iter_left == 7'd1) state <= IDLE;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign no_int     = busy;
    assign cache_sel  = (state == REPLAY);
    assign pc_halt    = cache_sel;
    assign cache_dout = cache_sel ? mem[idx] : 16'd0;

endmodule

// File: doc/jtdsp16_cache.md
# jtdsp16_cache

Do-loop instruction cache for the DSP16 core. It sits between program ROM fetch and the instruction decoder, on the decoder's upstream side. It consumes the decoder's `do_start`/`do_data` request and captures up to 15 loop-body words from `rom_dout` during the first pass. It then replays those words on `cache_dout` for the remaining iterations while holding the program counter, and supports `redo`, which replays the last captured body without a ROM pass.

## Interface
Parameters:
- `AW`, 4: cache index width; depth is 2^AW-1 = 15 words.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cen`  in  1  clock enable; all state advances only when `cen`=1.
- `do_start`  in  1  one-cen-cycle pulse from the decoder requesting do/redo.
- `do_data`  in  11  [10:7]=NI body length (0 means redo), [6:0]=K iteration count.
- `fetch`  in  1  an instruction word is consumed by the decoder this cen cycle.
- `rom_dout`  in  16  ROM instruction word.
- `cache_dout`  out  16  replayed instruction word; 0 when `cache_sel`=0.
- `cache_sel`  out  1  decoder must take its instruction from `cache_dout`.
- `pc_halt`  out  1  XAAU must not advance the PC.
- `no_int`  out  1  interrupts blocked; high whenever the block is not IDLE.
- `busy`  out  1  state is not IDLE.
- `fault`  out  1  sticky; set when `do_start` arrives while busy.

## Operation
- The cache is a 15x16 register array. It is not reset.
- The stored body length `ni_q` (4 bits) is reset to 0 and survives loop completion for later redo use.
- `iter_left` is a 7-bit counter. `idx` is the 4-bit write/read pointer.
- State machine states are IDLE, LOAD and REPLAY.
- IDLE, `do_start` with NI≠0 and K≥1:
  - `ni_q`<=NI and `iter_left`<=K-1.
  - The word on `rom_dout` in this same cen cycle (with `fetch`=1) is body word 0: it is written to mem[0] and `idx`<=1.
  - If NI=1 and K-1=0, stay IDLE. If NI=1 and K-1>0, go to REPLAY with `idx`<=0. Otherwise go to LOAD.
- IDLE, `do_start` with NI≠0 and K=0: treated as K=1, i.e. a single ROM pass is still captured.
- IDLE, `do_start` with NI=0 (redo):
  - If K=0 or `ni_q`=0, this is a no-op.
  - Otherwise `iter_left`<=K, `idx`<=0, go to REPLAY.
- LOAD, on `fetch`:
  - mem[idx]<=`rom_dout` and `idx`++.
  - When the written index is `ni_q`-1: if `iter_left`=0 go to IDLE, else go to REPLAY with `idx`<=0.
  - The PC advances normally during LOAD.
- REPLAY:
  - `cache_sel`=1, `pc_halt`=1, `cache_dout`=mem[idx] (combinational read).
  - On `fetch`, `idx`++. At `idx`=`ni_q`-1, `idx`<=0 and `iter_left`--.
  - When `iter_left` reaches 0 on the wrap, go to IDLE.
- `do_start` while not IDLE is ignored (loops do not nest) and sets `fault`.
- Fetch-less cycles (`fetch`=0) hold all state.

## Timing
- All state is registered on `posedge clk` when `cen`=1.
- `cache_sel`, `pc_halt`, `no_int` and `busy` are decoded from the registered state, so they become valid the cycle after the transition edge.
- A redo sampled at edge E gives `cache_sel`=1 from edge E onward, presenting mem[0].
- The last replayed word is presented while `cache_sel`=1. The IDLE transition occurs on its fetch edge, and the next word comes from ROM.
- Reset values: state IDLE, `idx`=0, `iter_left`=0, `ni_q`=0, `fault`=0, all outputs 0.
- Reset mid-loop aborts immediately. A subsequent redo is a no-op because `ni_q`=0.

## Test plan
- **do NI=3, K=4:** do_data=0x184, ROM words A,B,C → cache_dout sequence A,B,C ×3 with cache_sel=1, pc_halt=1 for exactly 9 fetches, then IDLE.
- **do NI=2, K=1:** ROM words X,Y → no REPLAY; cache_sel never asserted; busy high for 1 cycle only.
- **redo K=2 after the first test:** do_data=0x002 → A,B,C,A,B,C replayed, 6 fetches, with no LOAD phase.
- **Gaps:** `fetch` deasserted for 3 cycles mid-REPLAY → idx and cache_dout held; sequence resumes unbroken.
- **Nested request:** `do_start` during LOAD → ignored, fault=1 sticky, loop completes normally.
- **Reset during REPLAY:** all outputs 0 next cycle; redo K=5 afterwards → no-op, busy stays 0.
